uart_expmod_ctrl: RTL

- Command controller between the UART byte interfaces (uart_receive / uart_transmit) and an external exponent_modulus engine.
- Replaces the fixed switch/constant operand drive with a byte protocol: operands of WIDTH bits arrive over UART, the engine runs, and the result is returned over UART MSB first.
- Keeps a loadable stored key (exponent, modulus) so repeated operations need only send the value.

---
 rtl/uart_expmod_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_expmod_ctrl.sv
// Byte-protocol command controller: gathers operands over UART, runs an external modular
// exponentiation engine and returns the result MSB first. Holds a loadable (exponent, modulus) key.
module uart_expmod_ctrl #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rx_valid_in,
  input  logic [7:0]       rx_byte_in,
  output logic [7:0]       tx_byte_out,
  output logic             tx_trigger_out,
  input  logic             tx_busy_in,
  output logic             em_ready_out,
  output logic [WIDTH-1:0] em_value_out,
  output logic [WIDTH-1:0] em_exponent_out,
  output logic [WIDTH-1:0] em_modulus_out,
  input  logic [WIDTH-1:0] em_result_in,
  input  logic             em_busy_in,
  input  logic             em_valid_in,
  output logic             busy_out,
  output logic [WIDTH-1:0] last_result_out
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned CntW   = $clog2(3 * NBYTES + 1);
  localparam int unsigned GapW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CmdComputeByte = 8'hA5;
  localparam logic [7:0] CmdKeyByte     = 8'h5A;
  localparam logic [7:0] CmdLoadByte    = 8'h3C;
  localparam logic [7:0] ReplyOk        = 8'h4B;
  localparam logic [7:0] ReplyErr       = 8'hEE;

  typedef enum logic [2:0] {
    StIdle, StRxOps, StCheck, StLaunch, StWaitEm, StTxLoad, StTxSend, StTxHold
  } state_e;

  typedef enum logic [1:0] {CmdCompute, CmdKey, CmdLoad} cmd_e;

  state_e             state_q, state_d;
  cmd_e               cmd_q, cmd_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic [3*WIDTH-1:0] ops_q, ops_d;
  logic [WIDTH-1:0]   key_exp_q, key_exp_d, key_mod_q, key_mod_d;
  logic [WIDTH-1:0]   em_val_q, em_val_d, em_exp_q, em_exp_d, em_mod_q, em_mod_d;
  logic [WIDTH-1:0]   tx_sr_q, tx_sr_d, last_q, last_d;
  logic [CntW-1:0]    tx_left_q, tx_left_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               tx_trig_q, tx_trig_d;
  logic               em_ready;
  logic [CntW-1:0]    total;
  logic [WIDTH-1:0]   eff_mod;

  // Single reply byte parked in the top of the TX shift register.
  function automatic logic [WIDTH-1:0] reply_word(input logic [7:0] code);
    logic [WIDTH-1:0] w;
    w = '0;
    w[WIDTH-1 -: 8] = code;
    return w;
  endfunction

  always_comb begin
    unique case (cmd_q)
      CmdCompute: total = CntW'(3 * NBYTES);
      CmdKey:     total = CntW'(NBYTES);
      default:    total = CntW'(2 * NBYTES);
    endcase
    eff_mod = (cmd_q == CmdKey) ? key_mod_q : ops_q[WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    ops_d     = ops_q;
    key_exp_d = key_exp_q;
    key_mod_d = key_mod_q;
    em_val_d  = em_val_q;
    em_exp_d  = em_exp_q;
    em_mod_d  = em_mod_q;
    tx_sr_d   = tx_sr_q;
    tx_left_d = tx_left_q;
    tx_byte_d = tx_byte_q;
    tx_trig_d = 1'b0;
    last_d    = last_q;
    em_ready  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_valid_in) begin
          cnt_d   = '0;
          gap_d   = '0;
          ops_d   = '0;
          state_d = StRxOps;
          case (rx_byte_in)
            CmdComputeByte: cmd_d = CmdCompute;
            CmdKeyByte:     cmd_d = CmdKey;
            CmdLoadByte:    cmd_d = CmdLoad;
            default: begin
              tx_sr_d   = reply_word(ReplyErr);
              tx_left_d = CntW'(1);
              state_d   = StTxLoad;
            end
          endcase
        end
      end
      StRxOps: begin
        // Timeout takes priority over a byte arriving in the same cycle.
        if (gap_q == GapW'(TIMEOUT_CYCLES)) begin
          ops_d     = '0;
          tx_sr_d   = reply_word(ReplyErr);
          tx_left_d = CntW'(1);
          state_d   = StTxLoad;
        end else if (rx_valid_in) begin
          ops_d = {ops_q[3*WIDTH-9:0], rx_byte_in};
          cnt_d = cnt_q + CntW'(1);
          gap_d = '0;
          if (cnt_q + CntW'(1) == total) state_d = StCheck;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StCheck: begin
        if (eff_mod == '0) begin
          tx_sr_d   = reply_word(ReplyErr);
          tx_left_d = CntW'(1);
          state_d   = StTxLoad;
        end else if (cmd_q == CmdLoad) begin
          key_exp_d = ops_q[2*WIDTH-1:WIDTH];
          key_mod_d = ops_q[WIDTH-1:0];
          tx_sr_d   = reply_word(ReplyOk);
          tx_left_d = CntW'(1);
          state_d   = StTxLoad;
        end else begin
          em_val_d = (cmd_q == CmdKey) ? ops_q[WIDTH-1:0] : ops_q[3*WIDTH-1:2*WIDTH];
          em_exp_d = (cmd_q == CmdKey) ? key_exp_q : ops_q[2*WIDTH-1:WIDTH];
          em_mod_d = eff_mod;
          state_d  = StLaunch;
        end
      end
      StLaunch: begin
        if (!em_busy_in) begin
          em_ready = 1'b1;
          state_d  = StWaitEm;
        end
      end
      StWaitEm: begin
        if (em_valid_in) begin
          tx_sr_d   = em_result_in;
          last_d    = em_result_in;
          tx_left_d = CntW'(NBYTES);
          state_d   = StTxLoad;
        end
      end
      StTxLoad: begin
        if (!tx_busy_in) begin
          tx_byte_d = tx_sr_q[WIDTH-1 -: 8];
          tx_sr_d   = tx_sr_q << 8;
          tx_left_d = tx_left_q - CntW'(1);
          tx_trig_d = 1'b1;
          state_d   = StTxSend;
        end
      end
      StTxSend: state_d = StTxHold;
      StTxHold: begin
        if (!tx_busy_in) state_d = (tx_left_q != '0) ? StTxLoad : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      cmd_q     <= CmdCompute;
      cnt_q     <= '0;
      gap_q     <= '0;
      ops_q     <= '0;
      key_exp_q <= '0;
      key_mod_q <= '0;
      em_val_q  <= '0;
      em_exp_q  <= '0;
      em_mod_q  <= '0;
      tx_sr_q   <= '0;
      tx_left_q <= '0;
      tx_byte_q <= '0;
      tx_trig_q <= 1'b0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      ops_q     <= ops_d;
      key_exp_q <= key_exp_d;
      key_mod_q <= key_mod_d;
      em_val_q  <= em_val_d;
      em_exp_q  <= em_exp_d;
      em_mod_q  <= em_mod_d;
      tx_sr_q   <= tx_sr_d;
      tx_left_q <= tx_left_d;
      tx_byte_q <= tx_byte_d;
      tx_trig_q <= tx_trig_d;
      last_q    <= last_d;
    end
  end

  // Start strobe is combinational for two-cycle launch latency; suppressed while in reset.
  assign em_ready_out    = em_ready && !rst_in;
  assign tx_trigger_out  = tx_trig_q;
  assign tx_byte_out     = tx_byte_q;
  assign em_value_out    = em_val_q;
  assign em_exponent_out = em_exp_q;
  assign em_modulus_out  = em_mod_q;
  assign busy_out        = (state_q != StIdle);
  assign last_result_out = last_q;

endmodule
